axis_uart_rx_ext: RTL and testbench
===================================

# axis_uart_rx_ext

Parametrised UART receiver, successor to the fixed 8-bit receive path. It supports a runtime-selectable character length (5..MAX_DATA_WIDTH bits), none/odd/even parity and 1 or 2 stop bits. Each bit is recovered with a 3-sample majority vote at the bit centre, and each character is delivered on an AXI-Stream master with per-character error flags. It sits between the pad-level rx line and the register/FIFO layer of the UART subsystem.

## Interface
Parameters:
- MAX_DATA_WIDTH, 9: widest character supported; tdata width.
- DIVIDER_WIDTH, 32: width of the clocks-per-bit divider input.

Ports:
- Clocking and reset (already decided): one clock `clk_i`; reset `arstn_i`, asynchronous, active-low.
- clk_i  in  1  system clock.
- arstn_i  in  1  asynchronous active-low reset.
- rx_i  in  1  serial line, asynchronous to clk_i, idle high.
- clk_divider_i  in  DIVIDER_WIDTH  clk_i cycles per bit. Values below 4 are treated as 4.
- data_bits_i  in  4  character length. Values below 5 are treated as 5; values above MAX_DATA_WIDTH are treated as MAX_DATA_WIDTH.
- parity_odd_i  in  1  odd parity enable. Has priority over parity_even_i.
- parity_even_i  in  1  even parity enable. Both enables low means no parity bit.
- stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits.
- overrun_clr_i  in  1  single-cycle pulse that clears overrun_o.
- m_axis_tdata  out  MAX_DATA_WIDTH  received character, LSB-aligned, upper bits zero.
- m_axis_tuser  out  2  {parity_err, frame_err} for this character.
- m_axis_tvalid  out  1  character available.
- m_axis_tready  in  1  downstream accept.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- overrun_o  out  1  sticky: a character was dropped.

## Operation
- Synchroniser:
  - rx_i passes through a 2-flop synchroniser; the result is rx_s.
  - A falling edge is detected from rx_s and its 1-cycle delayed copy.
- Configuration latch:
  - In IDLE, a falling edge on rx_s latches divider, data bits, parity mode and stop bits, then moves to START.
  - Configuration changes mid-frame have no effect.
- Bit timer:
  - Counter runs 0..div-1; the terminal count ends the bit.
  - Samples are taken at counts h-1, h and h+1, where h = div>>1.
  - The bit value is the majority of the three samples.
- FSM states IDLE, START, DATA, PARITY, STOP, WAIT:
  - START: the timer starts on the falling-edge cycle (count 0). At end of bit, majority 1 means a false start and the FSM returns to IDLE with no output. Majority 0 moves to DATA.
  - DATA: bits are shifted in LSB first; a bit counter counts up to data_bits. Then go to PARITY if parity is enabled, otherwise STOP.
  - PARITY:
    - Expected bit is ~^data for odd parity and ^data for even parity.
    - A mismatch sets parity_err.
  - STOP:
    - Each stop bit is sampled; a 0 majority on any stop bit sets frame_err.
    - With two stop bits, both are checked.
    - The character commits at the h+1 sample of the last stop bit, not at end of bit, so back-to-back frames are not missed. Then go to WAIT.
  - WAIT: stays until rx_s is high (break condition), then returns to IDLE. A falling edge on the cycle WAIT exits is honoured.
- Output register (single entry):
  - On commit with m_axis_tvalid low, the register loads tdata and tuser and tvalid goes high.
  - On commit with m_axis_tvalid high and m_axis_tready low, the new character is dropped, the held character is kept, and overrun_o is set.
  - On commit in the same cycle as a handshake (tvalid && tready), the new character loads and no overrun is flagged.
  - tvalid drops after a handshake unless a load occurs in the same cycle.
- overrun_o:
  - Cleared by overrun_clr_i.
  - If set and clear coincide, set wins.
- Errored characters are still delivered with their tuser flags set.

## Timing
- Reset values:
  - m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tvalid = 0.
  - busy_o = 0, overrun_o = 0.
  - FSM in IDLE; synchroniser flops at 1.
- Reset asserted mid-frame aborts immediately. After release, the block waits for a fresh falling edge; the partial character is never output.
- Latency:
  - rx_i edge to falling-edge detect: 3 cycles.
  - Last stop bit's h+1 sample to m_axis_tvalid high: 1 cycle.
- tdata and tuser stay stable while tvalid && !tready.
- Tolerance: ±(h-1)/div bit-period drift over the full frame.

## Test plan
- 8N1, divider 16, send 0xA5 with tready high -> tdata 0x0A5, tuser 00, one valid pulse, busy_o low again after the stop bit.
- 7O2, divider 10, send 0x41 with correct parity 1 -> tdata 0x041, tuser 00. Repeat with the parity bit flipped -> tuser 10.
- 9E1, send 0x1FF with stop bit forced low -> tdata 0x1FF, tuser 01; no further output until the line returns high.
- tready held low, send 0x11 then 0x22 -> tdata stays 0x11 and overrun_o goes high. After a handshake, tvalid goes low. overrun_clr_i clears overrun_o.
- 2-cycle low glitch on rx_i at divider 16 -> false start; no tvalid, busy_o back to 0 after one bit period.
- arstn_i asserted during DATA bit 4 -> all outputs at reset values. After release, a full 0x3C frame is received correctly.

Source files
------------

// File: rtl/axis_uart_rx_ext.sv
// UART receiver: runtime character format, 3-sample majority vote,
// AXI-Stream character output with {parity_err, frame_err} in tuser.
module axis_uart_rx_ext #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int DIVIDER_WIDTH  = 32
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic                      rx_i,
  input  logic [DIVIDER_WIDTH-1:0]  clk_divider_i,
  input  logic [3:0]                data_bits_i,
  input  logic                      parity_odd_i,
  input  logic                      parity_even_i,
  input  logic                      stop_bits_i,
  input  logic                      overrun_clr_i,
  output logic [MAX_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]                m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int DW = DIVIDER_WIDTH;
  localparam int MW = MAX_DATA_WIDTH;
  localparam logic [3:0] MAX_BITS = 4'(MW);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT
  } state_t;

  logic sync_q, rx_s, rx_d;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= rx_i;
      rx_s   <= sync_q;
      rx_d   <= rx_s;
    end
  end

  logic          fall;
  logic [DW-1:0] div_c;
  logic [3:0]    nbits_c;

  assign fall  = rx_d & ~rx_s;
  assign div_c = (clk_divider_i < DW'(4)) ? DW'(4) : clk_divider_i;
  assign nbits_c = (data_bits_i < 4'd5)     ? 4'd5     :
                   (data_bits_i > MAX_BITS) ? MAX_BITS :
                   data_bits_i;

  state_t        state_q;
  logic [DW-1:0] div_q, cnt_q, h;
  logic [3:0]    nbits_q, bit_cnt_q;
  logic          par_en_q, par_odd_q, stop2_q, stop_cnt_q;
  logic          s0_q, s1_q, bit_q, fe_q, pe_q;
  logic [MW-1:0] data_q;

  logic at_s0, at_s1, at_s2, end_bit, maj, cur_bit;
  logic timing, start_c, last_stop, commit, par_exp;

  assign h       = div_q >> 1;
  assign at_s0   = cnt_q == h - DW'(1);
  assign at_s1   = cnt_q == h;
  assign at_s2   = cnt_q == h + DW'(1);
  assign end_bit = cnt_q == div_q - DW'(1);
  assign maj     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  // At the minimum divider the third sample lands on the last count
  assign cur_bit = at_s2 ? maj : bit_q;
  assign timing  = state_q inside {START, DATA, PARITY, STOP};
  assign start_c = fall && (state_q == IDLE || state_q == WAIT);
  assign last_stop = stop_cnt_q == stop2_q;
  assign commit  = (state_q == STOP) && at_s2 && last_stop;
  assign par_exp = par_odd_q ? ~^data_q : ^data_q;
  assign busy_o  = state_q != IDLE;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      nbits_q    <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      bit_q      <= 1'b1;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      if (timing) begin
        cnt_q <= end_bit ? '0 : cnt_q + DW'(1);
        if (at_s0) s0_q <= rx_s;
        if (at_s1) s1_q <= rx_s;
        if (at_s2) bit_q <= maj;
      end
      if (start_c) begin
        // The edge cycle itself is count 0 of the start bit
        state_q    <= START;
        cnt_q      <= DW'(1);
        div_q      <= div_c;
        nbits_q    <= nbits_c;
        par_en_q   <= parity_odd_i | parity_even_i;
        par_odd_q  <= parity_odd_i;
        stop2_q    <= stop_bits_i;
        stop_cnt_q <= 1'b0;
        bit_cnt_q  <= '0;
        fe_q       <= 1'b0;
        pe_q       <= 1'b0;
        data_q     <= '0;
      end else begin
        unique case (state_q)
          IDLE: state_q <= IDLE;
          START:
            if (end_bit) state_q <= cur_bit ? IDLE : DATA;
          DATA:
            if (end_bit) begin
              data_q[bit_cnt_q] <= cur_bit;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == nbits_q - 4'd1)
                state_q <= par_en_q ? PARITY : STOP;
            end
          PARITY:
            if (end_bit) begin
              pe_q    <= cur_bit != par_exp;
              state_q <= STOP;
            end
          STOP:
            if (at_s2) begin
              if (!maj) fe_q <= 1'b1;
              if (last_stop) state_q <= WAIT;
              else stop_cnt_q <= 1'b1;
            end
          WAIT:
            if (rx_s) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      if (commit && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tdata  <= data_q;
        m_axis_tuser  <= {pe_q, fe_q | ~maj};
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (commit && m_axis_tvalid && !m_axis_tready)
        overrun_o <= 1'b1;
      else if (overrun_clr_i)
        overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_uart_rx_ext.sv
// Bench for axis_uart_rx_ext: format table, corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_axis_uart_rx_ext;

  localparam int MW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arstn;
  logic          rx;
  logic [DW-1:0] clk_divider;
  logic [3:0]    data_bits;
  logic          parity_odd, parity_even, stop_bits;
  logic          overrun_clr;
  logic [MW-1:0] tdata;
  logic [1:0]    tuser;
  logic          tvalid, tready;
  logic          busy, overrun;

  always #5 clk = ~clk;

  axis_uart_rx_ext #(.MAX_DATA_WIDTH(MW), .DIVIDER_WIDTH(DW)) dut (
    .clk_i(clk),
    .arstn_i(arstn),
    .rx_i(rx),
    .clk_divider_i(clk_divider),
    .data_bits_i(data_bits),
    .parity_odd_i(parity_odd),
    .parity_even_i(parity_even),
    .stop_bits_i(stop_bits),
    .overrun_clr_i(overrun_clr),
    .m_axis_tdata(tdata),
    .m_axis_tuser(tuser),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .busy_o(busy),
    .overrun_o(overrun)
  );

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] got_d[$];
  logic [1:0]    got_u[$];
  logic          frame_bits[$];

  always @(negedge clk)
    if (tvalid && tready) begin
      got_d.push_back(tdata);
      got_u.push_back(tuser);
    end

  typedef struct {
    logic [8:0] d;
    int         nb;
    int         dv;
    bit         po;
    bit         pe;
    bit         s2;
    bit         pflip;
    logic [1:0] slow;
    logic [8:0] ed;
    logic [1:0] eu;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int eff_bits(input int n);
    return (n < 5) ? 5 : ((n > MW) ? MW : n);
  endfunction

  function automatic int eff_div(input int n);
    return (n < 4) ? 4 : n;
  endfunction

  task automatic set_cfg(input int dv, input int nb, input bit po,
                         input bit pe, input bit s2);
    clk_divider = DW'(dv);
    data_bits   = 4'(nb);
    parity_odd  = po;
    parity_even = pe;
    stop_bits   = s2;
  endtask

  task automatic build_frame(input logic [8:0] d, input int enb,
                             input bit pen, input bit pbit,
                             input bit s2, input logic [1:0] stop_v);
    frame_bits.delete();
    frame_bits.push_back(1'b0);
    for (int i = 0; i < enb; i++) frame_bits.push_back(d[i]);
    if (pen) frame_bits.push_back(pbit);
    frame_bits.push_back(stop_v[0]);
    if (s2) frame_bits.push_back(stop_v[1]);
  endtask

  task automatic drive_bits(input int dv, input int limit);
    for (int i = 0; i < frame_bits.size() && i < limit; i++) begin
      rx = frame_bits[i];
      step(dv);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    step(n);
  endtask

  task automatic expect_char(input string nm, input logic [8:0] ed,
                             input logic [1:0] eu);
    check({nm, " count"}, 32'(got_d.size()), 32'd1);
    if (got_d.size() > 0) begin
      check({nm, " tdata"}, 32'(got_d[0]), 32'(ed));
      check({nm, " tuser"}, 32'(got_u[0]), 32'(eu));
    end
    got_d.delete();
    got_u.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] md, d;
    logic [1:0] stop_v;
    int enb, edv, ones, nb, dv;
    bit pen, p, po, pe, s2, pbit, perr, ferr;

    tbl[0] = '{9'h0A5, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 9'h0A5, 2'b00};
    tbl[1] = '{9'h041, 7, 10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 9'h041, 2'b00};
    tbl[2] = '{9'h041, 7, 10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 9'h041, 2'b10};
    tbl[3] = '{9'h03F, 3, 2,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 9'h01F, 2'b00};
    tbl[4] = '{9'h155, 15, 7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 9'h155, 2'b00};
    tbl[5] = '{9'h000, 8, 9,  1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 9'h000, 2'b10};
    tbl[6] = '{9'h02A, 6, 8,  1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 9'h02A, 2'b01};
    tbl[7] = '{9'h0C3, 8, 11, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 9'h0C3, 2'b11};

    arstn = 1'b0;
    rx = 1'b1;
    overrun_clr = 1'b0;
    tready = 1'b1;
    set_cfg(16, 8, 1'b0, 1'b0, 1'b0);
    step(3);
    check("reset tdata", 32'(tdata), 32'd0);
    check("reset tuser", 32'(tuser), 32'd0);
    check("reset tvalid", 32'(tvalid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    arstn = 1'b1;
    step(5);

    foreach (tbl[i]) begin
      set_cfg(tbl[i].dv, tbl[i].nb, tbl[i].po, tbl[i].pe, tbl[i].s2);
      enb = eff_bits(tbl[i].nb);
      edv = eff_div(tbl[i].dv);
      md  = tbl[i].d & 9'((1 << enb) - 1);
      pen = tbl[i].po | tbl[i].pe;
      p   = tbl[i].po ? ~^md : ^md;
      build_frame(md, enb, pen, p ^ tbl[i].pflip, tbl[i].s2, ~tbl[i].slow);
      drive_bits(edv, 99);
      idle(2 * edv + 6);
      expect_char($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].eu);
      check($sformatf("tbl%0d busy", i), 32'(busy), 32'd0);
    end

    set_cfg(12, 9, 1'b0, 1'b1, 1'b0);
    build_frame(9'h1FF, 9, 1'b1, 1'b1, 1'b0, 2'b00);
    drive_bits(12, 99);
    step(36);
    check("break busy", 32'(busy), 32'd1);
    expect_char("break", 9'h1FF, 2'b01);
    rx = 1'b1;
    step(6);
    check("break released busy", 32'(busy), 32'd0);
    check("break extra chars", 32'(got_d.size()), 32'd0);
    idle(20);

    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    tready = 1'b0;
    build_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 2'b11);
    drive_bits(8, 99);
    idle(20);
    build_frame(9'h022, 8, 1'b0, 1'b0, 1'b0, 2'b11);
    drive_bits(8, 99);
    idle(20);
    check("ovr tvalid", 32'(tvalid), 32'd1);
    check("ovr tdata held", 32'(tdata), 32'h011);
    check("ovr flag", 32'(overrun), 32'd1);
    tready = 1'b1;
    step(1);
    tready = 1'b0;
    check("ovr tvalid after hs", 32'(tvalid), 32'd0);
    expect_char("ovr hs", 9'h011, 2'b00);
    check("ovr sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check("ovr cleared", 32'(overrun), 32'd0);
    tready = 1'b1;
    step(4);

    set_cfg(16, 8, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    step(2);
    rx = 1'b1;
    step(4);
    check("glitch busy", 32'(busy), 32'd1);
    step(16);
    check("glitch idle", 32'(busy), 32'd0);
    check("glitch no char", 32'(got_d.size()), 32'd0);
    idle(10);

    build_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 2'b11);
    drive_bits(16, 5);
    rx = frame_bits[5];
    step(8);
    arstn = 1'b0;
    #1;
    check("midrst tdata", 32'(tdata), 32'd0);
    check("midrst tuser", 32'(tuser), 32'd0);
    check("midrst tvalid", 32'(tvalid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst overrun", 32'(overrun), 32'd0);
    rx = 1'b1;
    step(3);
    arstn = 1'b1;
    step(40);
    check("midrst after busy", 32'(busy), 32'd0);
    check("midrst no char", 32'(got_d.size()), 32'd0);
    drive_bits(16, 99);
    idle(40);
    expect_char("midrst frame", 9'h03C, 2'b00);

    for (int n = 0; n < 30; n++) begin
      dv = $urandom_range(0, 20);
      nb = $urandom_range(0, 15);
      po = 1'($urandom_range(0, 1));
      pe = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      d  = 9'($urandom);
      pbit = 1'($urandom_range(0, 1));
      stop_v[0] = $urandom_range(0, 5) != 0;
      stop_v[1] = $urandom_range(0, 5) != 0;
      set_cfg(dv, nb, po, pe, s2);
      enb = eff_bits(nb);
      edv = eff_div(dv);
      pen = po | pe;
      md  = 9'(d % (1 << enb));
      ones = $countones(md) + int'(pbit);
      perr = pen && (po ? (ones % 2 == 0) : (ones % 2 == 1));
      ferr = !stop_v[0] || (s2 && !stop_v[1]);
      build_frame(d, enb, pen, pbit, s2, stop_v);
      drive_bits(edv, 99);
      idle(2 * edv + 6);
      expect_char($sformatf("rnd%0d", n), md, {perr, ferr});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
